// File: rtl/exe_pkg.sv
// Shared definitions for the selector/demultiplexer exercises: data width,
// slot occupancy encoding and the common select equation.
package exe_pkg;

  localparam int DATA_W = 3;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Routing select shared with the 2:1 selector: 0 -> channel 1, 1 -> channel 2.
  function automatic logic sel_f(input logic a, input logic b, input logic c);
    return (a & b) | ~c;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot with valid/ready handshake and a wrapping count of
// words loaded into it. A load and a drain in the same cycle replace the word
// without dropping valid.
module demux_slot
  import exe_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt,
  output logic             can_load
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next state: a load always wins (covers pass-through fill); otherwise a
  // drain empties the slot but leaves the stale word in place.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (load) begin
      state_d = SLOT_FULL;
      data_d  = data_in;
      cnt_d   = cnt_q + CNT_W'(1);
    end else if ((state_q == SLOT_FULL) && out_ready) begin
      state_d = SLOT_EMPTY;
    end
  end

  // Slot registers; reset discards any held word immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = (state_q == SLOT_FULL);
  assign out_data  = data_q;
  assign cnt       = cnt_q;
  assign can_load  = ~out_valid | out_ready;

endmodule

// File: rtl/demux_1to2_reg.sv
// Registered 1-to-2 demultiplexer. The select equation picks the destination
// slot; in_ready reflects only that slot, so a stalled channel never blocks
// traffic to the other one. in_valid has no path to in_ready.
module demux_1to2_reg
  import exe_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             sel,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);

  logic can1, can2;
  logic load1, load2;

  // Route decision and acceptance: the selected slot alone decides in_ready.
  always_comb begin
    sel      = sel_f(a, b, c);
    in_ready = sel ? can2 : can1;
    load1    = in_valid & in_ready & ~sel;
    load2    = in_valid & in_ready & sel;
  end

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1),
    .data_in   (in_data),
    .out_data  (out1_data),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .cnt       (cnt1),
    .can_load  (can1)
  );

  demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot2 (
    .clk       (clk),
    .rst       (rst),
    .load      (load2),
    .data_in   (in_data),
    .out_data  (out2_data),
    .out_valid (out2_valid),
    .out_ready (out2_ready),
    .cnt       (cnt2),
    .can_load  (can2)
  );

endmodule
